// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - request-driven intersection phase FSM with per-phase timer
// Optional pedestrian crossing (ped_pend latch, WALK phase) enabled by defining PED_REQ_EN.
module traffic_phase_scheduler #(
  parameter int TIMER_W        = 8,
  parameter int MAIN_MIN_CYC   = 20,
  parameter int SIDE_GREEN_CYC = 10,
  parameter int YELLOW_CYC     = 3,
  parameter int ALLRED_CYC     = 2,
  parameter int WALK_CYC       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALLRED_A    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
`ifdef PED_REQ_EN
    ALLRED_B    = 3'd6,
    WALK        = 3'd7
`else
    ALLRED_B    = 3'd6
`endif
  } state_t;

  // Timer load values are duration-1; a zero duration behaves as one cycle.
  localparam logic [TIMER_W-1:0] LD_MAIN   = TIMER_W'((MAIN_MIN_CYC   > 1) ? MAIN_MIN_CYC   - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_SIDE   = TIMER_W'((SIDE_GREEN_CYC > 1) ? SIDE_GREEN_CYC - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_YELLOW = TIMER_W'((YELLOW_CYC     > 1) ? YELLOW_CYC     - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_ALLRED = TIMER_W'((ALLRED_CYC     > 1) ? ALLRED_CYC     - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_WALK   = TIMER_W'((WALK_CYC       > 1) ? WALK_CYC       - 1 : 0);

  state_t             state;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               side_pend;
  logic               side_pend_nxt;
  logic               ped_pend;
  logic               ped_pend_nxt;
  logic               expired;
  logic               advance;

  function automatic logic [TIMER_W-1:0] load_for(input state_t s);
    case (s)
      MAIN_GREEN:  return LD_MAIN;
      MAIN_YELLOW: return LD_YELLOW;
      SIDE_GREEN:  return LD_SIDE;
      SIDE_YELLOW: return LD_YELLOW;
`ifdef PED_REQ_EN
      WALK:        return LD_WALK;
`endif
      default:     return LD_ALLRED;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      timer       <= LD_ALLRED;
      side_pend   <= 1'b0;
      ped_pend    <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      side_pend   <= side_pend_nxt;
      ped_pend    <= ped_pend_nxt;
      phase_start <= advance;
    end
  end

  assign expired = (timer == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (expired) state_nxt = MAIN_GREEN;
      end
      MAIN_GREEN: begin
        if (expired && (side_pend || ped_pend)) state_nxt = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        if (expired) state_nxt = ALLRED_A;
      end
      ALLRED_A: begin
`ifdef PED_REQ_EN
        if (expired) state_nxt = side_pend ? SIDE_GREEN : WALK;
`else
        if (expired) state_nxt = SIDE_GREEN;
`endif
      end
      SIDE_GREEN: begin
        if (expired) state_nxt = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        if (expired) state_nxt = ALLRED_B;
      end
      ALLRED_B: begin
`ifdef PED_REQ_EN
        if (expired) state_nxt = ped_pend ? WALK : MAIN_GREEN;
`else
        if (expired) state_nxt = MAIN_GREEN;
`endif
      end
`ifdef PED_REQ_EN
      WALK: begin
        if (expired) state_nxt = MAIN_GREEN;
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

  // Every timed phase exits on expiry, so a state change marks a phase entry.
  always_comb begin
    advance   = (state_nxt != state);
    timer_nxt = timer;
    if (advance) begin
      timer_nxt = load_for(state_nxt);
    end else if (!expired) begin
      timer_nxt = timer - TIMER_W'(1);
    end
  end

  // Clear on service entry takes priority over a request on that same edge.
  always_comb begin
    side_pend_nxt = side_pend | side_req;
    if (advance && (state_nxt == SIDE_GREEN)) side_pend_nxt = 1'b0;
  end

`ifdef PED_REQ_EN
  always_comb begin
    ped_pend_nxt = ped_pend | ped_req;
    if (advance && (state_nxt == WALK)) ped_pend_nxt = 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend_nxt   = 1'b0;
`endif

  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    walk       = 1'b0;
    case (state)
      MAIN_GREEN:  main_light = 3'b001;
      MAIN_YELLOW: main_light = 3'b010;
      SIDE_GREEN:  side_light = 3'b001;
      SIDE_YELLOW: side_light = 3'b010;
`ifdef PED_REQ_EN
      WALK:        walk = 1'b1;
`endif
      default: begin
        main_light = 3'b100;
        side_light = 3'b100;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;
  logic       phase_start;

  int vectors     = 0;
  int miscompares = 0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .phase      (phase),
    .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] exp_main(input int p);
    if (p == 1) return 3'b001;
    if (p == 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int p);
    if (p == 4) return 3'b001;
    if (p == 5) return 3'b010;
    return 3'b100;
  endfunction

  // Observes a phase from its first cycle for len cycles, optionally pulsing
  // requests (pmask bit0 side, bit1 ped) in cycle pulse_at; ends on the next phase's first cycle.
  task automatic run_phase(input string tag, input int p, input int len,
                           input int pulse_at, input logic [1:0] pmask);
    int bad;
    bad = 0;
    check({tag, "_phase"}, 32'(phase), 32'(p));
    check({tag, "_start"}, 32'(phase_start), 32'd1);
    check({tag, "_main"},  32'(main_light), 32'(exp_main(p)));
    check({tag, "_side"},  32'(side_light), 32'(exp_side(p)));
    check({tag, "_walk"},  32'(walk), (p == 7) ? 32'd1 : 32'd0);
    for (int i = 1; i <= len; i++) begin
      if (i > 1 && (phase !== 3'(p) || phase_start !== 1'b0)) bad++;
      if (pulse_at != 0 && i == pulse_at) begin
        if (pmask[0]) side_req = 1'b1;
        if (pmask[1]) ped_req  = 1'b1;
      end else if (pulse_at != 0 && i == pulse_at + 1) begin
        side_req = 1'b0;
        ped_req  = 1'b0;
      end
      step(1);
    end
    check({tag, "_len"}, 32'(bad), 32'd0);
  endtask

  task automatic side_cycle_tail(input string tag);
    run_phase({tag, "_sy"}, 5, 3, 0, 2'b00);
    run_phase({tag, "_ab"}, 6, 2, 0, 2'b00);
  endtask

  int bad_cnt;

  initial begin
    rst_n    = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;

    // Reset and startup
    step(2);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_main",  32'(main_light), 32'b100);
    check("rst_side",  32'(side_light), 32'b100);
    check("rst_walk",  32'(walk), 32'd0);
    check("rst_start", 32'(phase_start), 32'd0);
    rst_n = 1'b1;
    step(1);
    check("init2_phase", 32'(phase), 32'd0);
    check("init2_start", 32'(phase_start), 32'd0);
    step(1);
    check("boot_phase", 32'(phase), 32'd1);
    check("boot_main",  32'(main_light), 32'b001);
    check("boot_start", 32'(phase_start), 32'd1);
    step(1);
    check("boot_start_drop", 32'(phase_start), 32'd0);

    // Idle: main green rests indefinitely
    bad_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (phase !== 3'd1 || phase_start !== 1'b0 || main_light !== 3'b001 ||
          side_light !== 3'b100) bad_cnt++;
    end
    check("idle_hold", 32'(bad_cnt), 32'd0);

`ifndef PED_REQ_EN
    ped_req = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (phase !== 3'd1 || walk !== 1'b0) bad_cnt++;
    end
    ped_req = 1'b0;
    check("ped_ignored", 32'(bad_cnt), 32'd0);
`endif

    // Held side request on an expired main green: yellow two cycles later
    side_req = 1'b1;
    step(1);
    check("lat_k1_phase", 32'(phase), 32'd1);
    step(1);
    run_phase("held_my", 2, 3, 0, 2'b00);
    run_phase("held_ara", 3, 2, 0, 2'b00);
    run_phase("held_sg", 4, 10, 0, 2'b00);
    side_req = 1'b0;
    side_cycle_tail("held");
    run_phase("rep_mg", 1, 20, 0, 2'b00);
    run_phase("rep_my", 2, 3, 0, 2'b00);
    run_phase("rep_ara", 3, 2, 0, 2'b00);
    run_phase("rep_sg", 4, 10, 0, 2'b00);
    side_cycle_tail("rep");

    // Single-cycle pulse in main green cycle 5
    run_phase("pulse_mg", 1, 20, 5, 2'b01);
    run_phase("pulse_my", 2, 3, 0, 2'b00);
    run_phase("pulse_ara", 3, 2, 0, 2'b00);

    // Reset in side green cycle 4 with a request pending
    check("abort_sg_phase", 32'(phase), 32'd4);
    side_req = 1'b1;
    step(1);
    side_req = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_main",  32'(main_light), 32'b100);
    check("abort_side",  32'(side_light), 32'b100);
    check("abort_start", 32'(phase_start), 32'd0);
    step(1);
    check("abort_init2", 32'(phase), 32'd0);
    step(1);
    check("abort_mg_phase", 32'(phase), 32'd1);
    check("abort_mg_start", 32'(phase_start), 32'd1);
    bad_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (phase !== 3'd1) bad_cnt++;
    end
    check("abort_req_lost", 32'(bad_cnt), 32'd0);

`ifdef PED_REQ_EN
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(1);
    run_phase("ped0_my", 2, 3, 0, 2'b00);
    run_phase("ped0_ara", 3, 2, 0, 2'b00);
    run_phase("ped0_walk", 7, 8, 0, 2'b00);
    run_phase("both_mg", 1, 20, 3, 2'b11);
    run_phase("both_my", 2, 3, 0, 2'b00);
    run_phase("both_ara", 3, 2, 0, 2'b00);
    run_phase("both_sg", 4, 10, 0, 2'b00);
    side_cycle_tail("both");
    run_phase("both_walk", 7, 8, 0, 2'b00);
    run_phase("ped_mg", 1, 20, 2, 2'b10);
    run_phase("ped_my", 2, 3, 0, 2'b00);
    run_phase("ped_ara", 3, 2, 0, 2'b00);
    run_phase("ped_walk", 7, 8, 0, 2'b00);
    check("ped_back_phase", 32'(phase), 32'd1);
    check("ped_back_start", 32'(phase_start), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Request-driven phase scheduler for a two-road intersection with a pedestrian crossing. It owns the intersection's phase state machine and its per-phase duration timer, and drives the main-road and side-road lamp outputs. The main road rests in green. The side road is served only when a vehicle sensor request is latched, and the pedestrian crossing only when a walk request is latched. This block supersedes the fixed-alternation light controller wherever sensors are fitted.

## Interface
Parameters:
- TIMER_W, 8: phase timer width. Every duration parameter must be ≤ 2^TIMER_W − 1.
- MAIN_MIN_CYC, 20: minimum MAIN_GREEN length in cycles.
- SIDE_GREEN_CYC, 10: SIDE_GREEN length.
- YELLOW_CYC, 3: length of each yellow phase.
- ALLRED_CYC, 2: length of each all-red clearance phase, including the post-reset phase.
- WALK_CYC, 8: WALK length.
- Any duration set to 0 is treated as 1.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- side_req  in  1  side-road vehicle sensor, level or pulse, sampled every cycle.
- ped_req  in  1  pedestrian push-button, sampled every cycle. Ignored unless PED_REQ_EN is defined.
- main_light  out  3  {red, yellow, green}, one-hot.
- side_light  out  3  {red, yellow, green}, one-hot.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding.
- phase_start  out  1  one-cycle pulse in the first cycle of every phase.

## Operation
States, with their `phase` encodings:
- INIT=0
- MAIN_GREEN=1
- MAIN_YELLOW=2
- ALLRED_A=3
- SIDE_GREEN=4
- SIDE_YELLOW=5
- ALLRED_B=6
- WALK=7

Lamp decode, combinational from the state register:
- main_light: green=001 in MAIN_GREEN, yellow=010 in MAIN_YELLOW, red=100 in all other states.
- side_light: 001 in SIDE_GREEN, 010 in SIDE_YELLOW, 100 in all other states.
- walk=1 only in WALK.
- In no state are both roads non-red.

Timer:
- On every state entry, timer loads duration−1 and then decrements once per cycle.
- The state may exit only in the cycle where timer==0. A timed phase of N cycles therefore lasts exactly N cycles.
- In MAIN_GREEN the timer holds at 0 once expired.

Request latches:
- side_pend is set by side_req=1 at any clock edge. It is cleared on the edge that enters SIDE_GREEN. On that same edge, clear wins over set.
- ped_pend follows the same rules, cleared on the edge that enters WALK.
- A request raised during its own service phase is held for the next cycle of the sequence.

Transitions (all taken when timer==0):
- INIT → MAIN_GREEN.
- MAIN_GREEN → MAIN_YELLOW when side_pend, or ped_pend if PED_REQ_EN is defined. Otherwise MAIN_GREEN holds indefinitely.
- MAIN_YELLOW → ALLRED_A.
- ALLRED_A → SIDE_GREEN if side_pend; otherwise → WALK.
- SIDE_GREEN → SIDE_YELLOW → ALLRED_B.
- ALLRED_B → WALK if ped_pend; otherwise → MAIN_GREEN.
- WALK → MAIN_GREEN.
- When both requests are pending, side is served first and pedestrian second.
- Illegal or unreachable encodings → INIT.

Reset (rst_n=0 at an edge), effective the following cycle:
- state=INIT, timer=ALLRED_CYC−1.
- side_pend=ped_pend=0.
- main_light=side_light=100, walk=0, phase=0, phase_start=0.
- Reset during any phase, including mid-green, aborts immediately to all-red with no yellow phase.

## Timing
- The state, timer, latches and phase_start are registered. Lamps and `phase` are decoded from the state register with no extra latency.
- Request latency: side_req high in cycle k sets side_pend in cycle k+1. If MAIN_GREEN has already expired, MAIN_YELLOW is entered in cycle k+2.
- Post-reset: rst_n released in cycle r. INIT occupies ALLRED_CYC cycles, then MAIN_GREEN starts with phase_start=1.
- phase_start is registered and high together with the first cycle of the new `phase`. It is not asserted in the INIT cycle that follows reset.

## Configuration
- Macro: PED_REQ_EN.
- When defined:
  - ped_pend latch and WALK state are present.
  - ped_req can end MAIN_GREEN.
  - walk is driven as described above.
- When undefined:
  - ped_req is unconnected and walk is tied 0.
  - ped_pend and WALK are absent.
  - MAIN_GREEN exits only on side_pend.
  - ALLRED_A always → SIDE_GREEN, and ALLRED_B always → MAIN_GREEN.
  - Phase encoding 7 is illegal and recovers to INIT.

## Test plan
1. Reset/startup: rst_n=0 for 2 cycles, then released → main_light=side_light=100 and phase=0 for 2 cycles, then phase=1, main_light=001, phase_start=1 for one cycle.
2. No requests for 200 cycles → phase stays 1, main_light=001, side_light=100, no phase_start pulses.
3. side_req one-cycle pulse in MAIN_GREEN cycle 5 → MAIN_GREEN lasts exactly 20 cycles, then MAIN_YELLOW 3, ALLRED_A 2, SIDE_GREEN 10, SIDE_YELLOW 3, ALLRED_B 2, back to phase 1.
4. side_req held in MAIN_GREEN cycle 30 → phase=2 two cycles later. side_req held high throughout SIDE_GREEN → a second side cycle follows after MAIN_GREEN's 20-cycle minimum.
5. PED_REQ_EN defined:
   - ped_req alone → MAIN_GREEN 20, yellow 3, ALLRED_A 2, WALK 8 with walk=1 and both roads red, then MAIN_GREEN.
   - side_req and ped_req together → SIDE_GREEN first, then WALK after ALLRED_B.
6. rst_n=0 in SIDE_GREEN cycle 4 → next cycle phase=0, all lamps red, no yellow. The pending side request is lost and MAIN_GREEN follows 2 cycles after release.
